// File: rtl/prbs_gen.sv
// Parallel 8-bit PRBS word generator with idle preamble for LVDS link self-test.
// Optional error injection enabled by defining PRBS_GEN_ERR_INJ_EN.
module prbs_gen #(
  parameter logic [7:0] IDLE_WORD    = 8'h00,
  parameter int         PREAMBLE_LEN = 16,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             testen,
  input  logic             inject_err,
  output logic [7:0]       data,
  output logic             running,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_RUN
  } state_t;

  localparam logic [7:0] SEED = 8'h08;
  localparam logic [15:0] PRE_LAST =
    (PREAMBLE_LEN > 0) ? 16'(PREAMBLE_LEN - 1) : 16'd0;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [15:0]      pre_q, pre_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       data_q, data_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inj;

`ifdef PRBS_GEN_ERR_INJ_EN
  assign inj = inject_err;
`else
  logic unused_inject;
  assign unused_inject = inject_err;
  assign inj = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= testen;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    lfsr_d  = SEED;
    data_d  = IDLE_WORD;
    run_d   = 1'b0;
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          pre_d   = '0;
          state_d = (PREAMBLE_LEN == 0) ? S_RUN : S_PRE;
        end
        S_PRE: begin
          pre_d = pre_q + 16'd1;
          if (pre_q == PRE_LAST)
            state_d = S_RUN;
        end
        S_RUN: begin
          // bit0 flip touches only the output word, never the LFSR
          data_d = lfsr_q ^ {7'b0, inj};
          run_d  = 1'b1;
          lfsr_d = {lfsr_q[1] ^ lfsr_q[3],
                    lfsr_q[7] ^ lfsr_q[1] ^ lfsr_q[2],
                    lfsr_q[6] ^ lfsr_q[7],
                    lfsr_q[5] ^ lfsr_q[6],
                    lfsr_q[4] ^ lfsr_q[5],
                    lfsr_q[3] ^ lfsr_q[4],
                    lfsr_q[2] ^ lfsr_q[3],
                    lfsr_q[1] ^ lfsr_q[2]};
          if (~&cnt_q)
            cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      lfsr_q  <= SEED;
      data_q  <= IDLE_WORD;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data     = data_q;
  assign running  = run_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: preamble timing, sequence, injection,
// disable/re-enable, async reset, zero-length preamble and count saturation.
module tb_prbs_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        testen = 1'b0;
  logic        inject_err = 1'b0;
  logic [7:0]  data;
  logic        running;
  logic [31:0] word_cnt;

  logic        testen_z = 1'b0;
  logic [7:0]  data_z;
  logic        running_z;
  logic [2:0]  cnt_z;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  prbs_gen #(
    .IDLE_WORD(8'h00), .PREAMBLE_LEN(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rstn(rstn), .testen(testen),
    .inject_err(inject_err), .data(data),
    .running(running), .word_cnt(word_cnt)
  );

  prbs_gen #(
    .IDLE_WORD(8'h00), .PREAMBLE_LEN(0), .CNT_W(3)
  ) dut_z (
    .clk(clk), .rstn(rstn), .testen(testen_z),
    .inject_err(1'b0), .data(data_z),
    .running(running_z), .word_cnt(cnt_z)
  );

  typedef struct {
    logic        te;
    logic        inj;
    logic [7:0]  d;
    logic        run;
    logic [31:0] cnt;
  } vec_t;

`ifdef PRBS_GEN_ERR_INJ_EN
  localparam logic [7:0] W3 = 8'hE3;
`else
  localparam logic [7:0] W3 = 8'hE2;
`endif

  vec_t tv[$];

  function automatic vec_t mk(logic te, logic inj, logic [7:0] d,
                              logic run, logic [31:0] cnt);
    vec_t v;
    v.te = te; v.inj = inj; v.d = d; v.run = run; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // E0..E6: sync + 4 preamble cycles
    for (int i = 0; i < 7; i++) tv.push_back(mk(1, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 8'h08, 1, 1));
    tv.push_back(mk(1, 0, 8'h86, 1, 2));
    tv.push_back(mk(1, 1, W3,    1, 3));
    tv.push_back(mk(1, 0, 8'h89, 1, 4));
    tv.push_back(mk(1, 0, 8'hE6, 1, 5));
    tv.push_back(mk(1, 0, 8'hCA, 1, 6));
    // drop: two words still flow through the synchronizer
    tv.push_back(mk(0, 0, 8'h17, 1, 7));
    tv.push_back(mk(0, 0, 8'h8E, 1, 8));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 1, 8'h00, 0, 8));
    // re-enable: count clears when leaving IDLE
    tv.push_back(mk(1, 0, 8'h00, 0, 8));
    tv.push_back(mk(1, 0, 8'h00, 0, 8));
    for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 8'h00, 0, 0));
    tv.push_back(mk(1, 0, 8'h08, 1, 1));
    tv.push_back(mk(1, 0, 8'h86, 1, 2));
    tv.push_back(mk(1, 0, 8'hE2, 1, 3));

    repeat (2) @(posedge clk);
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_cnt", word_cnt, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_data", 32'(data), 32'h00);
      chk("idle_running", 32'(running), 32'h0);
      chk("idle_cnt", word_cnt, 32'h0);
    end

    foreach (tv[i]) begin
      testen = tv[i].te;
      inject_err = tv[i].inj;
      tick();
      chk($sformatf("vec%0d_data", i), 32'(data), 32'(tv[i].d));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(tv[i].run));
      chk($sformatf("vec%0d_cnt", i), word_cnt, tv[i].cnt);
    end
    inject_err = 1'b0;

    // async reset mid-run, between clock edges
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_data", 32'(data), 32'h00);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_cnt", word_cnt, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (running) begin
        n = i;
        break;
      end
    end
    // first edge after release is E0; seed appears after E0+7
    chk("arst_restart_edges", 32'(n), 32'd8);
    chk("arst_restart_seed", 32'(data), 32'h08);
    chk("arst_restart_cnt", word_cnt, 32'd1);

    // zero-length preamble, 3-bit saturating count
    testen_z = 1'b1;
    tick();
    tick();
    chk("z_e1_running", 32'(running_z), 32'h0);
    tick();
    chk("z_e2_data", 32'(data_z), 32'h00);
    tick();
    chk("z_e3_data", 32'(data_z), 32'h08);
    chk("z_e3_running", 32'(running_z), 32'h1);
    tick();
    chk("z_e4_data", 32'(data_z), 32'h86);
    repeat (10) tick();
    chk("z_sat_cnt", 32'(cnt_z), 32'd7);
    chk("z_sat_running", 32'(running_z), 32'h1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
